// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: opcode/funct encodings, ALU op bits,
// operand-select positions and the packed ID->EX control bundle.
package id_stage_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09,
                         OP_ORI     = 6'h0D, OP_LUI  = 6'h0F, OP_LW  = 6'h23,
                         OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03,
                         FN_JR   = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  // ALU op vector is {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}, MSB first
  localparam int ALU_OP_LUI = 0, ALU_OP_SRA = 1, ALU_OP_SRL = 2, ALU_OP_SLL = 3,
                 ALU_OP_XOR = 4, ALU_OP_OR  = 5, ALU_OP_NOR = 6, ALU_OP_AND = 7,
                 ALU_OP_SLTU = 8, ALU_OP_SLT = 9, ALU_OP_SUB = 10, ALU_OP_ADD = 11;

  localparam int SRC1_RS = 0, SRC1_SA = 1, SRC1_PC = 2;
  localparam int SRC2_RT = 0, SRC2_SIMM = 1, SRC2_ZIMM = 2, SRC2_8 = 3;

  typedef struct packed {
    logic [11:0] alu_op;
    logic [2:0]  src1_sel;
    logic [3:0]  src2_sel;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        rf_res_sel;
  } ctrl_t;

  localparam int ID_TO_EX_W = $bits(ctrl_t);

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF-side, forwarding, writeback and EX-side signals of the decode stage.
interface id_stage_pipe_if #(
  parameter int NUM_FWD = 3,
  parameter int PC_W    = 32
);
  logic                  flush;
  logic                  if_valid;
  logic [PC_W-1:0]       if_pc;
  logic                  if_ready;
  logic [31:0]           inst_rdata;
  logic [NUM_FWD-1:0]    fwd_we;
  logic [5*NUM_FWD-1:0]  fwd_waddr;
  logic [32*NUM_FWD-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]    fwd_pend;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [31:0]           rf_wdata;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [PC_W-1:0]       ex_pc;
  logic [31:0]           ex_inst;
  logic [11:0]           ex_alu_op;
  logic [2:0]            ex_src1_sel;
  logic [3:0]            ex_src2_sel;
  logic                  ex_ram_en;
  logic [3:0]            ex_ram_wen;
  logic                  ex_rf_we;
  logic [4:0]            ex_rf_waddr;
  logic                  ex_rf_res_sel;
  logic [31:0]           ex_rdata1;
  logic [31:0]           ex_rdata2;
  logic                  br_valid;
  logic [PC_W-1:0]       br_addr;
  logic                  stallreq;

  modport master (
    input  flush, if_valid, if_pc, inst_rdata, fwd_we, fwd_waddr, fwd_wdata, fwd_pend,
           rf_we, rf_waddr, rf_wdata, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_inst, ex_alu_op, ex_src1_sel, ex_src2_sel,
           ex_ram_en, ex_ram_wen, ex_rf_we, ex_rf_waddr, ex_rf_res_sel, ex_rdata1,
           ex_rdata2, br_valid, br_addr, stallreq
  );

  modport slave (
    output flush, if_valid, if_pc, inst_rdata, fwd_we, fwd_waddr, fwd_wdata, fwd_pend,
           rf_we, rf_waddr, rf_wdata, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_inst, ex_alu_op, ex_src1_sel, ex_src2_sel,
           ex_ram_en, ex_ram_wen, ex_rf_we, ex_rf_waddr, ex_rf_res_sel, ex_rdata1,
           ex_rdata2, br_valid, br_addr, stallreq
  );
endinterface

// File: rtl/id_stage_pipe_decode.sv
// Combinational MIPS decoder: instruction word -> EX control fields, operand-use
// flags and branch/jump class. Unsupported encodings decode as a NOP.
module id_stage_pipe_decode
  import id_stage_pipe_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm,
  output logic [25:0] idx,
  output logic        use_rs,
  output logic        use_rt,
  output logic        is_beq,
  output logic        is_bne,
  output logic        is_jmp,
  output logic        is_jr
);
  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rd;

  assign op  = inst[31:26];
  assign rs  = inst[25:21];
  assign rt  = inst[20:16];
  assign rd  = inst[15:11];
  assign imm = inst[15:0];
  assign fn  = inst[5:0];
  assign idx = inst[25:0];

  always_comb begin
    ctrl          = '0;
    ctrl.src1_sel = 3'(1 << SRC1_RS);
    ctrl.src2_sel = 4'(1 << SRC2_RT);
    use_rs        = 1'b0;
    use_rt        = 1'b0;
    is_beq        = 1'b0;
    is_bne        = 1'b0;
    is_jmp        = 1'b0;
    is_jr         = 1'b0;
    case (op)
      OP_SPECIAL: begin
        ctrl.rf_we    = 1'b1;
        ctrl.rf_waddr = rd;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        case (fn)
          FN_ADDU: ctrl.alu_op[ALU_OP_ADD]  = 1'b1;
          FN_SUBU: ctrl.alu_op[ALU_OP_SUB]  = 1'b1;
          FN_AND:  ctrl.alu_op[ALU_OP_AND]  = 1'b1;
          FN_OR:   ctrl.alu_op[ALU_OP_OR]   = 1'b1;
          FN_XOR:  ctrl.alu_op[ALU_OP_XOR]  = 1'b1;
          FN_NOR:  ctrl.alu_op[ALU_OP_NOR]  = 1'b1;
          FN_SLT:  ctrl.alu_op[ALU_OP_SLT]  = 1'b1;
          FN_SLTU: ctrl.alu_op[ALU_OP_SLTU] = 1'b1;
          // shifts take the amount from the sa field instead of rs
          FN_SLL: begin
            ctrl.alu_op[ALU_OP_SLL] = 1'b1;
            ctrl.src1_sel           = 3'(1 << SRC1_SA);
            use_rs                  = 1'b0;
          end
          FN_SRL: begin
            ctrl.alu_op[ALU_OP_SRL] = 1'b1;
            ctrl.src1_sel           = 3'(1 << SRC1_SA);
            use_rs                  = 1'b0;
          end
          FN_SRA: begin
            ctrl.alu_op[ALU_OP_SRA] = 1'b1;
            ctrl.src1_sel           = 3'(1 << SRC1_SA);
            use_rs                  = 1'b0;
          end
          FN_JR: begin
            ctrl.rf_we    = 1'b0;
            ctrl.rf_waddr = '0;
            use_rt        = 1'b0;
            is_jr         = 1'b1;
          end
          default: begin
            ctrl.rf_we    = 1'b0;
            ctrl.rf_waddr = '0;
            use_rs        = 1'b0;
            use_rt        = 1'b0;
          end
        endcase
      end
      OP_ADDIU: begin
        ctrl.alu_op[ALU_OP_ADD] = 1'b1;
        ctrl.src2_sel           = 4'(1 << SRC2_SIMM);
        ctrl.rf_we              = 1'b1;
        ctrl.rf_waddr           = rt;
        use_rs                  = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_op[ALU_OP_OR] = 1'b1;
        ctrl.src2_sel          = 4'(1 << SRC2_ZIMM);
        ctrl.rf_we             = 1'b1;
        ctrl.rf_waddr          = rt;
        use_rs                 = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op[ALU_OP_LUI] = 1'b1;
        ctrl.src2_sel           = 4'(1 << SRC2_ZIMM);
        ctrl.rf_we              = 1'b1;
        ctrl.rf_waddr           = rt;
      end
      OP_LW: begin
        ctrl.alu_op[ALU_OP_ADD] = 1'b1;
        ctrl.src2_sel           = 4'(1 << SRC2_SIMM);
        ctrl.ram_en             = 1'b1;
        ctrl.rf_we              = 1'b1;
        ctrl.rf_waddr           = rt;
        ctrl.rf_res_sel         = 1'b1;
        use_rs                  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op[ALU_OP_ADD] = 1'b1;
        ctrl.src2_sel           = 4'(1 << SRC2_SIMM);
        ctrl.ram_en             = 1'b1;
        ctrl.ram_wen            = 4'hF;
        use_rs                  = 1'b1;
        use_rt                  = 1'b1;
      end
      OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        is_beq = 1'b1;
      end
      OP_BNE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        is_bne = 1'b1;
      end
      OP_J: is_jmp = 1'b1;
      // link value pc+8 is formed by the EX adder
      OP_JAL: begin
        is_jmp                  = 1'b1;
        ctrl.alu_op[ALU_OP_ADD] = 1'b1;
        ctrl.src1_sel           = 3'(1 << SRC1_PC);
        ctrl.src2_sel           = 4'(1 << SRC2_8);
        ctrl.rf_we              = 1'b1;
        ctrl.rf_waddr           = 5'd31;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: IF->ID register with instruction hold, write-through GPR file,
// prioritised operand forwarding, load-use interlock and branch/jump resolution.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int NUM_FWD    = 3,
  parameter int PC_W       = 32,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  id_stage_pipe_if.master bus
);
  logic                  valid_r;
  logic                  hold_vld;
  logic [PC_W-1:0]       pc_r;
  logic [31:0]           inst_hold;
  logic [31:0]           inst;
  logic [31:0]           gpr [32];
  ctrl_t                 ctrl;
  logic [ID_TO_EX_W-1:0] ctrl_bus;
  logic [4:0]            rs, rt;
  logic [15:0]           imm;
  logic [25:0]           idx;
  logic                  use_rs, use_rt, is_beq, is_bne, is_jmp, is_jr;
  logic [31:0]           rf_rs, rf_rt, rdata1, rdata2;
  logic                  hit1, hit2, pend1, pend2;
  logic                  hazard, ex_valid, fire, accept, taken, br_valid;
  logic [PC_W-1:0]       pcp4, br_target, j_target;

  assign inst = hold_vld ? inst_hold : bus.inst_rdata;

  id_stage_pipe_decode u_decode (
    .inst   (inst),
    .ctrl   (ctrl),
    .rs     (rs),
    .rt     (rt),
    .imm    (imm),
    .idx    (idx),
    .use_rs (use_rs),
    .use_rt (use_rt),
    .is_beq (is_beq),
    .is_bne (is_bne),
    .is_jmp (is_jmp),
    .is_jr  (is_jr)
  );

  always_ff @(posedge clk) begin
    if (bus.rf_we && bus.rf_waddr != 5'd0) gpr[bus.rf_waddr] <= bus.rf_wdata;
  end

  // same-cycle WB write bypasses the array so the regfile reads as write-through
  assign rf_rs = (rs == 5'd0) ? 32'd0 :
                 (bus.rf_we && bus.rf_waddr == rs) ? bus.rf_wdata : gpr[rs];
  assign rf_rt = (rt == 5'd0) ? 32'd0 :
                 (bus.rf_we && bus.rf_waddr == rt) ? bus.rf_wdata : gpr[rt];

  always_comb begin
    rdata1 = rf_rs;
    rdata2 = rf_rt;
    hit1   = 1'b0;
    hit2   = 1'b0;
    pend1  = 1'b0;
    pend2  = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit1 && bus.fwd_we[i] && bus.fwd_waddr[5*i +: 5] == rs && rs != 5'd0) begin
        hit1   = 1'b1;
        rdata1 = bus.fwd_wdata[32*i +: 32];
        pend1  = bus.fwd_pend[i];
      end
      if (!hit2 && bus.fwd_we[i] && bus.fwd_waddr[5*i +: 5] == rt && rt != 5'd0) begin
        hit2   = 1'b1;
        rdata2 = bus.fwd_wdata[32*i +: 32];
        pend2  = bus.fwd_pend[i];
      end
    end
  end

  assign hazard    = valid_r & ((use_rs & pend1) | (use_rt & pend2));
  assign ex_valid  = valid_r & ~hazard & ~bus.flush;
  assign fire      = ex_valid & bus.ex_ready;
  assign accept    = bus.if_valid & bus.if_ready;
  assign pcp4      = pc_r + PC_W'(4);
  assign br_target = pcp4 + {{(PC_W-18){imm[15]}}, imm, 2'b00};
  assign j_target  = {pcp4[PC_W-1:28], idx, 2'b00};
  assign taken     = (is_beq & (rdata1 == rdata2)) | (is_bne & (rdata1 != rdata2)) |
                     is_jmp | is_jr;
  assign br_valid  = fire & taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r   <= 1'b0;
      hold_vld  <= 1'b0;
      pc_r      <= '0;
      inst_hold <= '0;
    end else begin
      if (bus.flush) begin
        valid_r <= 1'b0;
      end else if (accept) begin
        // without a delay slot the inst fetched alongside a taken branch is wrong-path
        valid_r <= DELAY_SLOT || !br_valid;
        pc_r    <= bus.if_pc;
      end else if (fire) begin
        valid_r <= 1'b0;
      end
      if (bus.flush || fire) begin
        hold_vld <= 1'b0;
      end else if (valid_r && !hold_vld) begin
        hold_vld  <= 1'b1;
        inst_hold <= bus.inst_rdata;
      end
    end
  end

  assign ctrl_bus = valid_r ? ctrl : '0;
  assign {bus.ex_alu_op, bus.ex_src1_sel, bus.ex_src2_sel, bus.ex_ram_en, bus.ex_ram_wen,
          bus.ex_rf_we, bus.ex_rf_waddr, bus.ex_rf_res_sel} = ctrl_bus;

  assign bus.if_ready  = ~valid_r | fire;
  assign bus.ex_valid  = ex_valid;
  assign bus.stallreq  = hazard;
  assign bus.ex_pc     = valid_r ? pc_r : '0;
  assign bus.ex_inst   = valid_r ? inst : '0;
  assign bus.ex_rdata1 = valid_r ? rdata1 : '0;
  assign bus.ex_rdata2 = valid_r ? rdata2 : '0;
  assign bus.br_valid  = br_valid;
  assign bus.br_addr   = !br_valid ? '0 : is_jr ? rdata1[PC_W-1:0] :
                         is_jmp ? j_target : br_target;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe (no delay slot): hold register, forwarding priority,
// load-use interlock, branch/jump redirect, flush and asynchronous reset.
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] I_LUI  = 32'h3C011234;
  localparam logic [31:0] I_ADDU = 32'h00A01821;
  localparam logic [31:0] I_BEQ  = 32'h10220004;
  localparam logic [31:0] I_JAL  = 32'h0C000010;

  id_stage_pipe_if #(.NUM_FWD(3), .PC_W(32)) bus ();

  id_stage_pipe #(.NUM_FWD(3), .PC_W(32), .DELAY_SLOT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept in cycle N, SRAM data presented in N+1; returns in N+1 after settling
  task automatic send(input logic [31:0] pc, input logic [31:0] ins);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    #1;
    chk("send_if_ready", bus.if_ready, 1'b1);
    step();
    bus.if_valid   = 1'b0;
    bus.inst_rdata = ins;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] garb [3];
    garb = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
    bus.flush = 0; bus.if_valid = 0; bus.if_pc = '0; bus.inst_rdata = '0;
    bus.fwd_we = '0; bus.fwd_waddr = '0; bus.fwd_wdata = '0; bus.fwd_pend = '0;
    bus.rf_we = 0; bus.rf_waddr = '0; bus.rf_wdata = '0; bus.ex_ready = 0;

    #12;
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_if_ready", bus.if_ready, 1'b1);
    chk("rst_br_valid", bus.br_valid, 1'b0);
    chk("rst_ex_pc", bus.ex_pc, 32'h0);
    rst = 1'b1;
    step();

    bus.rf_we = 1; bus.rf_waddr = 5'd1; bus.rf_wdata = 32'd7; step();
    bus.rf_waddr = 5'd2; step();
    bus.rf_waddr = 5'd5; bus.rf_wdata = 32'h55; step();
    bus.rf_we = 0;

    // hold register keeps the accepted word while EX back-pressures
    bus.ex_ready = 0;
    send(32'h100, I_LUI);
    chk("hold_ex_valid", bus.ex_valid, 1'b1);
    chk("hold_ex_pc", bus.ex_pc, 32'h100);
    chk("hold_inst0", bus.ex_inst, I_LUI);
    for (int k = 0; k < 3; k++) begin
      step();
      bus.inst_rdata = garb[k];
      if (k == 2) bus.ex_ready = 1;
      #1;
      chk("hold_inst", bus.ex_inst, I_LUI);
    end
    chk("hold_fire_if_ready", bus.if_ready, 1'b1);
    chk("lui_alu_op", bus.ex_alu_op, 12'h001);
    chk("lui_waddr", bus.ex_rf_waddr, 5'd1);
    chk("lui_src2", bus.ex_src2_sel, 4'b0100);
    step();
    chk("hold_after_fire_valid", bus.ex_valid, 1'b0);
    chk("idle_inst_zero", bus.ex_inst, 32'h0);

    // forwarding priority, r0 immunity, regfile fallback and write-through
    bus.ex_ready  = 0;
    bus.fwd_we    = 3'b111;
    bus.fwd_waddr = {5'd0, 5'd5, 5'd5};
    bus.fwd_wdata = {32'hDEAD, 32'h22, 32'h11};
    bus.fwd_pend  = 3'b000;
    send(32'h200, I_ADDU);
    chk("fwd_slot0", bus.ex_rdata1, 32'h11);
    chk("fwd_r0", bus.ex_rdata2, 32'h0);
    chk("addu_waddr", bus.ex_rf_waddr, 5'd3);
    chk("addu_alu_op", bus.ex_alu_op, 12'h800);
    bus.fwd_we = 3'b010; #1;
    chk("fwd_slot1", bus.ex_rdata1, 32'h22);
    bus.fwd_we = 3'b000; #1;
    chk("fwd_regfile", bus.ex_rdata1, 32'h55);
    bus.rf_we = 1; bus.rf_waddr = 5'd5; bus.rf_wdata = 32'h66; #1;
    chk("rf_write_through", bus.ex_rdata1, 32'h66);
    bus.rf_we = 0;
    bus.ex_ready = 1;
    step();
    chk("fwd_drained", bus.ex_valid, 1'b0);

    // load-use interlock: slot0 pending wins over a ready slot1 match
    bus.fwd_we    = 3'b011;
    bus.fwd_waddr = {5'd0, 5'd5, 5'd5};
    bus.fwd_wdata = {32'h0, 32'h22, 32'h77};
    bus.fwd_pend  = 3'b001;
    send(32'h300, I_ADDU);
    chk("lu_stall1", bus.stallreq, 1'b1);
    chk("lu_exv1", bus.ex_valid, 1'b0);
    chk("lu_ifr1", bus.if_ready, 1'b0);
    step();
    bus.inst_rdata = 32'hFFFF_FFFF; #1;
    chk("lu_stall2", bus.stallreq, 1'b1);
    chk("lu_exv2", bus.ex_valid, 1'b0);
    step();
    bus.fwd_pend = 3'b000;
    bus.fwd_wdata = {32'h0, 32'h22, 32'h99}; #1;
    chk("lu_stall3", bus.stallreq, 1'b0);
    chk("lu_exv3", bus.ex_valid, 1'b1);
    chk("lu_value", bus.ex_rdata1, 32'h99);
    chk("lu_inst", bus.ex_inst, I_ADDU);
    step();
    chk("lu_once", bus.ex_valid, 1'b0);
    bus.fwd_we = 3'b000;

    // taken BEQ squashes the same-cycle accepted inst
    send(32'h1000, I_BEQ);
    bus.if_valid = 1; bus.if_pc = 32'h1004; #1;
    chk("beq_br_valid", bus.br_valid, 1'b1);
    chk("beq_br_addr", bus.br_addr, 32'h1014);
    chk("beq_if_ready", bus.if_ready, 1'b1);
    step();
    bus.if_valid = 0; bus.inst_rdata = I_LUI; #1;
    chk("beq_pulse", bus.br_valid, 1'b0);
    chk("beq_squash", bus.ex_valid, 1'b0);
    step();
    chk("beq_squash2", bus.ex_valid, 1'b0);

    send(32'h3000_5000, I_JAL);
    chk("jal_br_valid", bus.br_valid, 1'b1);
    chk("jal_br_addr", bus.br_addr, 32'h3000_0040);
    chk("jal_waddr", bus.ex_rf_waddr, 5'd31);
    chk("jal_src1", bus.ex_src1_sel, 3'b100);
    chk("jal_src2", bus.ex_src2_sel, 4'b1000);
    step();
    chk("jal_done", bus.ex_valid, 1'b0);

    // flush with a pending taken branch held in the stage
    bus.ex_ready = 0;
    send(32'h2000, I_BEQ);
    chk("fl_exv_pre", bus.ex_valid, 1'b1);
    chk("fl_br_pre", bus.br_valid, 1'b0);
    step();
    bus.inst_rdata = 32'hFFFF_FFFF; #1;
    chk("fl_hold_set", dut.hold_vld, 1'b1);
    bus.flush = 1; bus.ex_ready = 1; #1;
    chk("fl_br_valid", bus.br_valid, 1'b0);
    chk("fl_ex_valid", bus.ex_valid, 1'b0);
    step();
    bus.flush = 0; bus.ex_ready = 0; #1;
    chk("fl_after_exv", bus.ex_valid, 1'b0);
    chk("fl_after_ifr", bus.if_ready, 1'b1);
    chk("fl_hold_clr", dut.hold_vld, 1'b0);
    send(32'h3000, 32'h3C01ABCD);
    chk("fl_new_inst", bus.ex_inst, 32'h3C01ABCD);
    bus.ex_ready = 1;
    step();

    // flush and accept together: the accepted inst is dropped
    bus.flush = 1; bus.if_valid = 1; bus.if_pc = 32'h6000;
    step();
    bus.flush = 0; bus.if_valid = 0; bus.inst_rdata = I_LUI; #1;
    chk("flacc_exv", bus.ex_valid, 1'b0);
    chk("flacc_pc", bus.ex_pc, 32'h0);

    // asynchronous reset mid-stream
    bus.ex_ready = 0;
    send(32'h4000, I_LUI);
    chk("mr_exv_pre", bus.ex_valid, 1'b1);
    rst = 0; #1;
    chk("mr_exv", bus.ex_valid, 1'b0);
    chk("mr_br", bus.br_valid, 1'b0);
    chk("mr_pc", bus.ex_pc, 32'h0);
    step();
    rst = 1; #1;
    chk("mr_ifr", bus.if_ready, 1'b1);
    chk("mr_exv_post", bus.ex_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
